pool_a1_cu: RTL

- Control unit for the 2x2, stride-2 pooling layer that follows the first convolution layer.
- Consumer end of the conv layer's map handshake: receives start_from_previous when a 28x28 feature map is complete in the ping-pong buffer, and returns end_to_previous.
- Generates read addresses in window order and drives the pooling datapath (clear/enable).
- Generates write addresses into its own ping-pong output buffer, handshaking with the next layer through start_to_next/end_from_next.

---
 rtl/pool_a1_cu.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pool_a1_cu.sv
// Control unit for the 2x2 / stride-2 pooling layer after conv1: walks the input map window by
// window, drives the pooling datapath and exchanges whole-map handshakes with both neighbours.
module pool_a1_cu #(
    parameter int IFM_SIZE              = 28,
    parameter int NUMBER_OF_IFM         = 6,
    parameter int MEM_LATENCY           = 1,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int MAP_W                 = $clog2(NUMBER_OF_IFM)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    output logic                             end_to_previous,
    output logic                             ifm_sel_current,
    output logic                             ifm_enable_read_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
    output logic                             pool_clear,
    output logic                             pool_enable,
    output logic                             ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
    output logic                             ifm_sel_next,
    output logic                             start_to_next,
    input  logic                             end_from_next,
    output logic [MAP_W-1:0]                 map_index,
    output logic                             ready
);

    localparam int CNT_W = $clog2(IFM_SIZE_NEXT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [CNT_W-1:0]                 LAST_RC  = CNT_W'(IFM_SIZE_NEXT - 1);
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] LAST_WR  = ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
    localparam logic [MAP_W-1:0]                 LAST_MAP = MAP_W'(NUMBER_OF_IFM - 1);

    logic [1:0]                       state_q, state_d;
    logic [1:0]                       k_q, k_d;
    logic [CNT_W-1:0]                 col_q, col_d;
    logic [CNT_W-1:0]                 row_q, row_d;
    logic [MEM_LATENCY-1:0]           en_pipe_q, en_pipe_d;
    logic [MEM_LATENCY-1:0]           clr_pipe_q, clr_pipe_d;
    logic [MEM_LATENCY:0]             wr_pipe_q, wr_pipe_d;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_q, wr_addr_d;
    logic                             out_pending_q, out_pending_d;
    logic                             sel_cur_q, sel_cur_d;
    logic                             sel_next_q, sel_next_d;
    logic [MAP_W-1:0]                 map_q, map_d;

    logic rd_en;
    logic wr_en;
    logic last_write;
    logic handoff;

    assign rd_en      = (state_q == READ);
    assign wr_en      = wr_pipe_q[MEM_LATENCY];
    assign last_write = wr_en & (wr_addr_q == LAST_WR);
    assign handoff    = out_pending_q & end_from_next;

    // Window order: k walks the 2x2 window (k[0] = column offset, k[1] = row offset).
    assign ifm_address_read_current = ADDRESS_SIZE_IFM'(
        (2 * int'(row_q) + int'(k_q[1])) * IFM_SIZE + 2 * int'(col_q) + int'(k_q[0]));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        k_d           = k_q;
        col_d         = col_q;
        row_d         = row_q;
        sel_cur_d     = sel_cur_q;
        map_d         = map_q;

        case (state_q)
            IDLE: begin
                if (start_from_previous && !out_pending_q) state_d = READ;
            end
            READ: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    if (col_q == LAST_RC) begin
                        col_d = '0;
                        if (row_q == LAST_RC) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (last_write) begin
                    state_d   = IDLE;
                    sel_cur_d = ~sel_cur_q;
                    map_d     = (map_q == LAST_MAP) ? '0 : map_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        en_pipe_d[0]  = rd_en;
        clr_pipe_d[0] = rd_en & (k_q == 2'd0);
        wr_pipe_d[0]  = rd_en & (k_q == 2'd3);
        for (int i = 1; i < MEM_LATENCY; i++) begin
            en_pipe_d[i]  = en_pipe_q[i-1];
            clr_pipe_d[i] = clr_pipe_q[i-1];
        end
        // The write needs one more stage than the data: the accumulator registers the 4th element.
        for (int i = 1; i <= MEM_LATENCY; i++) begin
            wr_pipe_d[i] = wr_pipe_q[i-1];
        end

        wr_addr_d     = wr_en ? (last_write ? '0 : wr_addr_q + 1'b1) : wr_addr_q;
        out_pending_d = last_write | (out_pending_q & ~handoff);
        sel_next_d    = sel_next_q ^ handoff;
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop clears on async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            en_pipe_q     <= '0;
            clr_pipe_q    <= '0;
            wr_pipe_q     <= '0;
            wr_addr_q     <= '0;
            out_pending_q <= 1'b0;
            sel_cur_q     <= 1'b0;
            sel_next_q    <= 1'b0;
            map_q         <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            col_q         <= col_d;
            row_q         <= row_d;
            en_pipe_q     <= en_pipe_d;
            clr_pipe_q    <= clr_pipe_d;
            wr_pipe_q     <= wr_pipe_d;
            wr_addr_q     <= wr_addr_d;
            out_pending_q <= out_pending_d;
            sel_cur_q     <= sel_cur_d;
            sel_next_q    <= sel_next_d;
            map_q         <= map_d;
        end
    end

    // IDLE-derived levels are masked by reset so every output reads 0 while reset is held.
    assign ready                   = ~reset & (state_q == IDLE);
    assign end_to_previous         = ~reset & (state_q == IDLE) & ~out_pending_q;
    assign ifm_enable_read_current = rd_en;
    assign pool_enable             = en_pipe_q[MEM_LATENCY-1];
    assign pool_clear              = clr_pipe_q[MEM_LATENCY-1];
    assign ifm_enable_write_next   = wr_en;
    assign ifm_address_write_next  = wr_addr_q;
    assign start_to_next           = handoff;
    assign ifm_sel_current         = sel_cur_q;
    assign ifm_sel_next            = sel_next_q;
    assign map_index               = map_q;

endmodule
